// File: rtl/input_detect_pkg.sv
// Shared constants and width helper for the switch detector.
package input_detect_pkg;

    localparam int MODE_STRICT   = 0;
    localparam int MODE_PRIORITY = 1;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/input_detect_sync_sw_debounce.sv
// Two-flop synchroniser followed by a whole-vector debounce filter.
module sw_debounce
    import input_detect_pkg::*;
#(
    parameter int N        = 8,
    parameter int DEBOUNCE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw,
    output logic [N-1:0] stable
);

    localparam int              CW      = clog2_min1(DEBOUNCE);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE - 1);

    logic [N-1:0]  s1_r;
    logic [N-1:0]  s2_r;
    logic [N-1:0]  cand_r;
    logic [CW-1:0] cnt_r;
    logic [N-1:0]  stable_r;

    // Synchronise, then accept a candidate once it has held for DEBOUNCE cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r     <= {N{1'b0}};
            s2_r     <= {N{1'b0}};
            cand_r   <= {N{1'b0}};
            cnt_r    <= {CW{1'b0}};
            stable_r <= {N{1'b0}};
        end else begin
            s1_r <= sw;
            s2_r <= s1_r;
            if (s2_r != cand_r) begin
                cand_r <= s2_r;
                cnt_r  <= {CW{1'b0}};
            end else if (cnt_r == CNT_MAX) begin
                stable_r <= cand_r;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign stable = stable_r;

endmodule

// File: rtl/input_detect_sync.sv
// Debounced switch-bank encoder: strict one-hot or priority index, with change strobe.
module input_detect_sync
    import input_detect_pkg::*;
#(
    parameter int N        = 8,
    parameter int DEBOUNCE = 4,
    parameter int MODE     = MODE_STRICT,
    localparam int W       = clog2_min1(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw,
    output logic         good,
    output logic [W-1:0] input_out,
    output logic         changed
);

    logic [N-1:0] stable_s;
    logic [6:0]   ones_s;
    logic [W-1:0] pos_s;
    logic         good_nxt_s;
    logic [W-1:0] idx_nxt_s;
    logic         good_r;
    logic [W-1:0] idx_r;
    logic         changed_r;

    sw_debounce #(
        .N        (N),
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw     (sw),
        .stable (stable_s)
    );

    // Count set bits and track the highest set position (last write wins).
    always_comb begin
        ones_s = 7'd0;
        pos_s  = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (stable_s[i]) begin
                ones_s = ones_s + 7'd1;
                pos_s  = W'(i);
            end else begin
                ones_s = ones_s;
                pos_s  = pos_s;
            end
        end
    end

    // Map the bit census to a code for the selected mode.
    always_comb begin
        good_nxt_s = 1'b0;
        idx_nxt_s  = {W{1'b0}};
        if (MODE == MODE_PRIORITY) begin
            good_nxt_s = (ones_s != 7'd0);
            idx_nxt_s  = pos_s;
        end else if (ones_s == 7'd1) begin
            good_nxt_s = 1'b1;
            idx_nxt_s  = pos_s;
        end else begin
            good_nxt_s = 1'b0;
            idx_nxt_s  = {W{1'b0}};
        end
    end

    // Output registers; the strobe fires when the registered code is about to differ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_r    <= 1'b0;
            idx_r     <= {W{1'b0}};
            changed_r <= 1'b0;
        end else begin
            good_r    <= good_nxt_s;
            idx_r     <= idx_nxt_s;
            changed_r <= ({good_nxt_s, idx_nxt_s} != {good_r, idx_r});
        end
    end

    assign good      = good_r;
    assign input_out = idx_r;
    assign changed   = changed_r;

endmodule

// File: tb/tb_input_detect_sync.sv
// Directed bench: strict and priority instances at N=8/DEBOUNCE=4, plus N=16/DEBOUNCE=1.
module tb_input_detect_sync;

    logic        clk;
    logic        rst_n;
    logic [7:0]  sw0;
    logic [7:0]  sw1;
    logic [15:0] sw2;
    logic        good0, good1, good2;
    logic [2:0]  idx0, idx1;
    logic [3:0]  idx2;
    logic        chg0, chg1, chg2;

    int vectors;
    int miscompares;
    int pulses0;
    int pulses1;

    typedef struct {
        logic [7:0] sw;
        logic       g0;
        logic [2:0] i0;
        int         c0;
        logic       g1;
        logic [2:0] i1;
        int         c1;
    } vec_t;

    vec_t vecs[10];

    input_detect_sync #(.N(8), .DEBOUNCE(4), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sw(sw0),
        .good(good0), .input_out(idx0), .changed(chg0)
    );

    input_detect_sync #(.N(8), .DEBOUNCE(4), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sw(sw1),
        .good(good1), .input_out(idx1), .changed(chg1)
    );

    input_detect_sync #(.N(16), .DEBOUNCE(1), .MODE(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .sw(sw2),
        .good(good2), .input_out(idx2), .changed(chg2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge, then sample 1 time unit later and tally strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        if (chg0) pulses0++;
        if (chg1) pulses1++;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        pulses0     = 0;
        pulses1     = 0;
        rst_n       = 1'b0;
        sw0         = 8'h10;
        sw1         = 8'h10;
        sw2         = 16'h8000;

        vecs[0] = '{8'h01, 1'b1, 3'd0, 1, 1'b1, 3'd0, 1};
        vecs[1] = '{8'h02, 1'b1, 3'd1, 1, 1'b1, 3'd1, 1};
        vecs[2] = '{8'h81, 1'b0, 3'd0, 1, 1'b1, 3'd7, 1};
        vecs[3] = '{8'h00, 1'b0, 3'd0, 0, 1'b0, 3'd0, 1};
        vecs[4] = '{8'h10, 1'b1, 3'd4, 1, 1'b1, 3'd4, 1};
        vecs[5] = '{8'h30, 1'b0, 3'd0, 1, 1'b1, 3'd5, 1};
        vecs[6] = '{8'h03, 1'b0, 3'd0, 0, 1'b1, 3'd1, 1};
        vecs[7] = '{8'h80, 1'b1, 3'd7, 1, 1'b1, 3'd7, 1};
        vecs[8] = '{8'hC0, 1'b0, 3'd0, 1, 1'b1, 3'd7, 0};
        vecs[9] = '{8'h01, 1'b1, 3'd0, 1, 1'b1, 3'd0, 1};

        // Reset state while switches are already set.
        ticks(3);
        chk("rst_good0", 32'(good0), 32'd0);
        chk("rst_idx0",  32'(idx0),  32'd0);
        chk("rst_chg0",  32'(chg0),  32'd0);
        chk("rst_good2", 32'(good2), 32'd0);
        chk("rst_idx2",  32'(idx2),  32'd0);

        // Release and watch exact acceptance latency (8 edges vs 5 edges).
        rst_n = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            chk($sformatf("lat_good0_e%0d", e), 32'(good0), 32'(e >= 8));
            chk($sformatf("lat_idx0_e%0d", e),  32'(idx0),  (e >= 8) ? 32'd4 : 32'd0);
            chk($sformatf("lat_chg0_e%0d", e),  32'(chg0),  32'(e == 8));
            chk($sformatf("lat_good2_e%0d", e), 32'(good2), 32'(e >= 5));
            chk($sformatf("lat_idx2_e%0d", e),  32'(idx2),  (e >= 5) ? 32'd15 : 32'd0);
            chk($sformatf("lat_chg2_e%0d", e),  32'(chg2),  32'(e == 5));
        end
        ticks(2);

        // Table of settled vectors for both modes.
        for (int v = 0; v < 10; v++) begin
            sw0     = vecs[v].sw;
            sw1     = vecs[v].sw;
            pulses0 = 0;
            pulses1 = 0;
            ticks(12);
            chk($sformatf("v%0d_good0", v), 32'(good0), 32'(vecs[v].g0));
            chk($sformatf("v%0d_idx0", v),  32'(idx0),  32'(vecs[v].i0));
            chk($sformatf("v%0d_chg0", v),  32'(pulses0), 32'(vecs[v].c0));
            chk($sformatf("v%0d_good1", v), 32'(good1), 32'(vecs[v].g1));
            chk($sformatf("v%0d_idx1", v),  32'(idx1),  32'(vecs[v].i1));
            chk($sformatf("v%0d_chg1", v),  32'(pulses1), 32'(vecs[v].c1));
        end

        // Glitches of 2 and 3 cycles away from 8'h01 are rejected.
        for (int g = 2; g <= 3; g++) begin
            pulses0 = 0;
            sw0     = 8'h02;
            ticks(g);
            sw0     = 8'h01;
            ticks(12);
            chk($sformatf("glitch%0d_idx0", g),  32'(idx0),  32'd0);
            chk($sformatf("glitch%0d_good0", g), 32'(good0), 32'd1);
            chk($sformatf("glitch%0d_chg0", g),  32'(pulses0), 32'd0);
        end

        // Held change is accepted exactly at edge 8.
        sw0 = 8'h02;
        ticks(7);
        chk("hold_idx0_e7", 32'(idx0), 32'd0);
        tick();
        chk("hold_idx0_e8", 32'(idx0), 32'd1);
        chk("hold_chg0_e8", 32'(chg0), 32'd1);
        tick();
        chk("hold_chg0_e9", 32'(chg0), 32'd0);

        // Reset in the middle of a debounce from 8'h01 to 8'h08.
        sw0 = 8'h01;
        ticks(12);
        chk("pre_mid_good0", 32'(good0), 32'd1);
        sw0 = 8'h08;
        ticks(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_good0", 32'(good0), 32'd0);
        chk("mid_rst_idx0",  32'(idx0),  32'd0);
        ticks(2);
        rst_n   = 1'b1;
        pulses0 = 0;
        ticks(7);
        chk("post_rst_good0_e7", 32'(good0), 32'd0);
        chk("post_rst_chg0_e7",  32'(pulses0), 32'd0);
        tick();
        chk("post_rst_good0_e8", 32'(good0), 32'd1);
        chk("post_rst_idx0_e8",  32'(idx0),  32'd3);
        chk("post_rst_chg0_e8",  32'(chg0),  32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
